// File: rtl/sal_arbiter_rr_n.sv
// N-to-1 round-robin arbiter with packet lock, data mux and valid/ready output.
// Optional macro SAL_ARB_OUT_REG_EN inserts a 2-entry skid buffer on the output side.
module sal_arbiter_rr_n #(
    parameter int REQ_CNT     = 4,
    parameter int REQ_CNT_LG2 = $clog2(REQ_CNT),
    parameter int DATA_WIDTH  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQ_CNT-1:0]     req_arr_i,
    input  logic [DATA_WIDTH-1:0]  data_arr_i [0:REQ_CNT-1],
    input  logic [REQ_CNT-1:0]     last_arr_i,
    output logic [REQ_CNT-1:0]     gnt_arr_o,
    output logic                   req_o,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   last_o,
    output logic [REQ_CNT_LG2-1:0] src_o,
    input  logic                   gnt_i
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [REQ_CNT_LG2-1:0] prev_r;
    logic [REQ_CNT_LG2-1:0] prev_nxt_s;
    logic [REQ_CNT_LG2-1:0] owner_r;
    logic [REQ_CNT_LG2-1:0] owner_nxt_s;
    logic [REQ_CNT_LG2-1:0] win_idx_s;
    logic                   win_vld_s;
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic                   sel_last_s;
    logic                   acc_rdy_s;
    logic                   accept_s;

    // (base + ofs) mod REQ_CNT; ofs never exceeds REQ_CNT so one subtraction suffices
    function automatic logic [REQ_CNT_LG2-1:0] wrap_idx(
        input logic [REQ_CNT_LG2-1:0] base,
        input int                     ofs
    );
        int sum;
        sum = int'(base) + ofs;
        sum = (sum >= REQ_CNT) ? (sum - REQ_CNT) : sum;
        return sum[REQ_CNT_LG2-1:0];
    endfunction

    // Winner selection: rotating priority search in IDLE, forced owner in LOCKED
    always_comb begin
        win_idx_s = owner_r;
        win_vld_s = 1'b0;
        case (state_r)
            ST_LOCKED: begin
                win_idx_s = owner_r;
                win_vld_s = req_arr_i[owner_r];
            end
            ST_IDLE: begin
                // Scan from farthest to nearest so the nearest requester overwrites last
                for (int i = REQ_CNT; i >= 1; i--) begin
                    win_idx_s = req_arr_i[wrap_idx(prev_r, i)] ? wrap_idx(prev_r, i) : win_idx_s;
                end
                win_vld_s = |req_arr_i;
            end
            default: begin
                win_idx_s = owner_r;
                win_vld_s = 1'b0;
            end
        endcase
    end

    assign sel_data_s = data_arr_i[win_idx_s];
    assign sel_last_s = last_arr_i[win_idx_s];
    assign accept_s   = win_vld_s & acc_rdy_s & ~rst;

    // Pointer and lock bookkeeping, advanced only on an accepted beat
    always_comb begin
        prev_nxt_s  = prev_r;
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        if (accept_s) begin
            prev_nxt_s = win_idx_s;
            if (sel_last_s) begin
                state_nxt_s = ST_IDLE;
            end else begin
                state_nxt_s = ST_LOCKED;
                owner_nxt_s = win_idx_s;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r  <= REQ_CNT_LG2'(REQ_CNT - 1);
            state_r <= ST_IDLE;
            owner_r <= {REQ_CNT_LG2{1'b0}};
        end else begin
            prev_r  <= prev_nxt_s;
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    // Requester-side accept strobe, one-hot on the accepted requester
    always_comb begin
        gnt_arr_o = {REQ_CNT{1'b0}};
        if (accept_s) begin
            gnt_arr_o[win_idx_s] = 1'b1;
        end else begin
            gnt_arr_o = {REQ_CNT{1'b0}};
        end
    end

`ifdef SAL_ARB_OUT_REG_EN

    logic                   head_vld_r;
    logic [DATA_WIDTH-1:0]  head_data_r;
    logic                   head_last_r;
    logic [REQ_CNT_LG2-1:0] head_src_r;
    logic                   skid_vld_r;
    logic [DATA_WIDTH-1:0]  skid_data_r;
    logic                   skid_last_r;
    logic [REQ_CNT_LG2-1:0] skid_src_r;
    logic                   pop_s;

    // Accept only while the skid slot is free, so gnt_i never reaches gnt_arr_o
    assign acc_rdy_s = ~skid_vld_r;
    assign pop_s     = head_vld_r & gnt_i;

    // Two-entry skid buffer: head drives the outputs, skid absorbs one stalled beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld_r  <= 1'b0;
            head_data_r <= {DATA_WIDTH{1'b0}};
            head_last_r <= 1'b0;
            head_src_r  <= {REQ_CNT_LG2{1'b0}};
            skid_vld_r  <= 1'b0;
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_last_r <= 1'b0;
            skid_src_r  <= {REQ_CNT_LG2{1'b0}};
        end else if (pop_s && skid_vld_r) begin
            head_vld_r  <= 1'b1;
            head_data_r <= skid_data_r;
            head_last_r <= skid_last_r;
            head_src_r  <= skid_src_r;
            skid_vld_r  <= 1'b0;
            skid_data_r <= {DATA_WIDTH{1'b0}};
            skid_last_r <= 1'b0;
            skid_src_r  <= {REQ_CNT_LG2{1'b0}};
        end else if (accept_s && (pop_s || !head_vld_r)) begin
            head_vld_r  <= 1'b1;
            head_data_r <= sel_data_s;
            head_last_r <= sel_last_s;
            head_src_r  <= win_idx_s;
        end else if (accept_s) begin
            skid_vld_r  <= 1'b1;
            skid_data_r <= sel_data_s;
            skid_last_r <= sel_last_s;
            skid_src_r  <= win_idx_s;
        end else if (pop_s) begin
            head_vld_r  <= 1'b0;
            head_data_r <= {DATA_WIDTH{1'b0}};
            head_last_r <= 1'b0;
            head_src_r  <= {REQ_CNT_LG2{1'b0}};
        end else begin
            head_vld_r  <= head_vld_r;
            skid_vld_r  <= skid_vld_r;
        end
    end

    assign req_o  = head_vld_r;
    assign data_o = head_data_r;
    assign last_o = head_last_r;
    assign src_o  = head_src_r;

`else

    assign acc_rdy_s = gnt_i;

    // Zero-latency output path straight from the winner
    always_comb begin
        req_o  = 1'b0;
        data_o = {DATA_WIDTH{1'b0}};
        last_o = 1'b0;
        src_o  = {REQ_CNT_LG2{1'b0}};
        if (win_vld_s && !rst) begin
            req_o  = 1'b1;
            data_o = sel_data_s;
            last_o = sel_last_s;
            src_o  = win_idx_s;
        end else begin
            req_o  = 1'b0;
            data_o = {DATA_WIDTH{1'b0}};
        end
    end

`endif

endmodule

// File: doc/sal_arbiter_rr_n.md
Name: sal_arbiter_rr_n

Overview:
- Parametrised N-to-1 round-robin arbiter with a data mux and a valid/ready downstream handshake.
- Generalises the fixed 4-to-1 arbiter to any REQ_CNT ≥ 2.
- Adds packet lock: once a requester wins, it holds the grant until its last beat.
- Sits in front of shared ports (memory controller command queue, NoC egress) where multi-beat transfers must not interleave.

Parameters:
- REQ_CNT, 4, number of requesters; must be ≥ 2, need not be a power of two.
- REQ_CNT_LG2, $clog2(REQ_CNT), width of the source index and the pointer.
- DATA_WIDTH, 64, payload width per requester.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_arr_i  input  REQ_CNT  per-requester valid.
- data_arr_i  input  DATA_WIDTH x [0:REQ_CNT-1]  per-requester payload (unpacked array).
- last_arr_i  input  REQ_CNT  per-requester last-beat flag; qualified by req_arr_i.
- gnt_arr_o  output  REQ_CNT  per-requester accept; one-hot or zero.
- req_o  output  1  downstream valid.
- data_o  output  DATA_WIDTH  downstream payload.
- last_o  output  1  downstream last-beat flag.
- src_o  output  REQ_CNT_LG2  index of the requester driving data_o.
- gnt_i  input  1  downstream ready.

Behaviour:
- Reset (asynchronous, takes effect immediately): prev_winner = REQ_CNT-1, state = IDLE, owner = 0.
  - Outputs during reset: req_o = 0, data_o = 0, last_o = 0, src_o = 0, gnt_arr_o = 0.
  - Reset mid-packet drops the lock; there is no recovery of the partial packet.
- Downstream transfer occurs when req_o & gnt_i.
- Requester-side accept: gnt_arr_o[k] = 1 only in the cycle requester k's beat is transferred.
- Requesters must hold req/data/last stable until accepted. This is not checked.
- States:
  - IDLE: winner = first k with req_arr_i[k] = 1, searching (prev_winner+1) mod REQ_CNT upward with wrap.
    - If no request: req_o = 0, data_o = 0, last_o = 0, src_o = 0.
  - LOCKED: winner is forced to owner regardless of other requests.
    - If req_arr_i[owner] = 0: req_o = 0 and no other requester is served.
- Outputs (no-register build): req_o, data_o, last_o and src_o are driven from the winner combinationally. Zero latency.
- On each transfer:
  - prev_winner ← winner.
  - If last = 0: state ← LOCKED, owner ← winner.
  - If last = 1: state ← IDLE.
  - A single-beat packet (last = 1 in IDLE) never enters LOCKED.
- The pointer advances only on a transfer. A stalled winner (gnt_i = 0) keeps priority, and winner selection does not change while req inputs are unchanged.
- Wrap-around: prev_winner = REQ_CNT-1 searches from index 0. The modulo must be correct for non-power-of-two REQ_CNT (e.g. 5: index 4 → 0).
- Fairness bound: a continuously requesting input waits at most REQ_CNT-1 packets.
- Throughput: one beat per cycle while gnt_i = 1.
  - Back-to-back packets from different requesters need no idle cycle.
  - The IDLE search in the cycle after a last beat uses the updated pointer.

Optional Feature:
- Macro: SAL_ARB_OUT_REG_EN.
- Defined: a 2-entry skid buffer holding {data, last, src} is inserted at the output.
  - req_o, data_o, last_o and src_o come from flops, giving 1-cycle latency.
  - gnt_arr_o depends only on buffer occupancy, not on gnt_i. No combinational path from gnt_i to any output.
  - Internal accept occurs when the buffer holds fewer than 2 entries. The pointer and lock update on internal accept, not on downstream transfer.
  - Full throughput is preserved. When the buffer is full, gnt_arr_o = 0.
  - Reset empties the buffer.
- Undefined: purely combinational output path, exactly as in Behaviour.

Test Plan:
- REQ_CNT=4, after reset, req_arr_i=4'b1111, all last=1, gnt_i=1 → src_o sequence 0,1,2,3,0; gnt_arr_o = 0001, 0010, 0100, 1000, 0001.
- Requester 2 sends a 3-beat packet (last=0,0,1) while req 0/1/3 are held high → src_o=2 for 3 consecutive transfers, then src_o=3. gnt_arr_o[0,1,3] stay 0 during the packet.
- In LOCKED with owner 1, req_arr_i[1] drops for 2 cycles while req 0 is high → req_o=0 for those 2 cycles, then owner 1 resumes. Requester 0 is never granted mid-packet.
- gnt_i=0 for 5 cycles with requests from 1 and 3 and prev_winner=0 → req_o=1, src_o=1 stable, gnt_arr_o=0. Then gnt_i=1 → 1 transfers, followed by 3.
- REQ_CNT=5, only req 4 and req 0 active, single beats → alternation 4,0,4,0 verifies non-power-of-two wrap. Assert rst mid-packet → outputs 0 immediately; after release, arbitration starts from index 0.
- SAL_ARB_OUT_REG_EN defined, gnt_i toggling 1,0,1,0 → no beat lost or duplicated, data_o order matches accept order, gnt_arr_o unchanged by same-cycle gnt_i.
